// File: rtl/animated_sprite.sv
// -----------------------------------------------------------------------------
// animated_sprite
//
// Multi-frame, palette-indexed sprite renderer with integer upscaling,
// colour-key transparency and a built-in animation sequencer. It sits after
// the video timing generator. Its RGB and opaque flag feed the layer
// compositor.
//
// Frames are stacked vertically in one index ROM, so frame f starts at row
// f*HEIGHT. The index ROM is img_word() and the palette ROM is pal_word().
// Both are constant functions of the address, and synthesis turns them into
// ROM logic. Replace those two functions to change the artwork.
//
// The pixel path has a fixed latency of 5 cycles from hcount/vcount to
// RGB/opaque.
//   S0  box test and ROM address; frame index sampled here
//   S1  index ROM read
//   S2  index ROM output register
//   S3  palette ROM read and colour-key test
//   S4  output register
//
// Reset asserts asynchronously. rst_n_in must be released synchronously to
// pixel_clk_in.
//
// Ports
//   pixel_clk_in    pixel clock
//   rst_n_in        asynchronous active-low reset
//   x_in, y_in      sprite top-left corner in screen pixels
//   hcount_in,
//   vcount_in       current pixel position
//   frame_start_in  1-cycle pulse at the start of each video frame
//   anim_en_in      1 = sequencer advances, 0 = hold the current frame
//   oneshot_in      0 = loop the frames, 1 = stop at the last frame
//   restart_in      pulse: back to frame 0; clears the hold count and done
//   frame_idx_out   animation frame currently displayed
//   done_out        oneshot finished: last frame shown for HOLD_FRAMES frames
//   opaque_out      pixel is inside the sprite and its index is not KEY_IDX
//   red_out, green_out,
//   blue_out        pixel colour; 0 when opaque_out is 0
// -----------------------------------------------------------------------------
module animated_sprite #(
  parameter int WIDTH       = 256,
  parameter int HEIGHT      = 256,
  parameter int NUM_FRAMES  = 2,
  parameter int PAL_DEPTH   = 256,
  parameter int SCALE_LOG2  = 0,
  parameter int HOLD_FRAMES = 4,
  parameter int KEY_IDX     = 0
) (
  input  logic        pixel_clk_in,
  input  logic        rst_n_in,
  input  logic [10:0] x_in,
  input  logic [9:0]  y_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        frame_start_in,
  input  logic        anim_en_in,
  input  logic        oneshot_in,
  input  logic        restart_in,
  output logic [((NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1)-1:0] frame_idx_out,
  output logic        done_out,
  output logic        opaque_out,
  output logic [7:0]  red_out,
  output logic [7:0]  green_out,
  output logic [7:0]  blue_out
);

  localparam int FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int HOLD_W  = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam int IDX_W   = (PAL_DEPTH > 1) ? $clog2(PAL_DEPTH) : 1;
  localparam int DEPTH   = WIDTH * HEIGHT * NUM_FRAMES;
  localparam int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [12:0]        BOX_W      = 13'(WIDTH << SCALE_LOG2);
  localparam logic [12:0]        BOX_H      = 13'(HEIGHT << SCALE_LOG2);
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [IDX_W-1:0]   KEY        = IDX_W'(KEY_IDX);

  // Index ROM contents: source column plus global row. Row 0 of frame 0
  // therefore starts with index 0 (the colour key).
  function automatic logic [IDX_W-1:0] img_word(input logic [ADDR_W-1:0] a);
    return IDX_W'((int'(a) % WIDTH) + (int'(a) / WIDTH));
  endfunction

  // Palette ROM contents.
  function automatic logic [23:0] pal_word(input logic [IDX_W-1:0] i);
    logic [7:0] lo;
    lo = 8'(i);
    return {lo, ~lo, (int'(i) >= 256) ? 8'hFF : 8'h3C};
  endfunction

  // ---------------------------------------------------------------------------
  // Animation sequencer
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {RUN, PAUSE, DONE} seq_state_t;

  seq_state_t         state, state_nxt;
  logic [FRAME_W-1:0] frame_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
  logic               done_nxt;

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= RUN;
      frame_idx_out <= '0;
      hold_cnt      <= '0;
      done_out      <= 1'b0;
    end else begin
      state         <= state_nxt;
      frame_idx_out <= frame_nxt;
      hold_cnt      <= hold_nxt;
      done_out      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    frame_nxt = frame_idx_out;
    hold_nxt  = hold_cnt;
    done_nxt  = done_out;
    if (restart_in) begin
      // restart overrides any frame_start arriving in the same cycle
      state_nxt = RUN;
      frame_nxt = '0;
      hold_nxt  = '0;
      done_nxt  = 1'b0;
    end else begin
      case (state)
        RUN, PAUSE: begin
          if (!anim_en_in) begin
            state_nxt = PAUSE;
          end else begin
            state_nxt = RUN;
            if (frame_start_in) begin
              if (hold_cnt == HOLD_LAST) begin
                hold_nxt = '0;
                if (frame_idx_out == LAST_FRAME) begin
                  if (oneshot_in) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                  end else begin
                    frame_nxt = '0;
                  end
                end else begin
                  frame_nxt = frame_idx_out + FRAME_W'(1);
                end
              end else begin
                hold_nxt = hold_cnt + HOLD_W'(1);
              end
            end
          end
        end
        DONE: begin
          // dropping oneshot resumes looping; the last frame is held again
          // before the sequence wraps to frame 0
          if (frame_start_in && !oneshot_in) begin
            state_nxt = RUN;
            done_nxt  = 1'b0;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel pipeline
  // ---------------------------------------------------------------------------
  logic signed [11:0] dx, dy;
  logic [11:0]        col, row;
  logic               box_hit;
  logic [ADDR_W-1:0]  addr;

  // Signed offsets, so a sprite hanging off the right edge never wraps
  // back into column 0.
  assign dx      = $signed({1'b0, hcount_in}) - $signed({1'b0, x_in});
  assign dy      = $signed({2'b00, vcount_in}) - $signed({2'b00, y_in});
  assign box_hit = !dx[11] && !dy[11] && ({1'b0, dx} < BOX_W) && ({1'b0, dy} < BOX_H);
  assign col     = $unsigned(dx) >> SCALE_LOG2;
  assign row     = $unsigned(dy) >> SCALE_LOG2;
  assign addr    = ADDR_W'(col)
                 + (ADDR_W'(row) + ADDR_W'(frame_idx_out) * ADDR_W'(HEIGHT)) * ADDR_W'(WIDTH);

  logic              in_box_p0, in_box_p1, in_box_p2;
  logic [ADDR_W-1:0] addr_p0;
  logic [IDX_W-1:0]  idx_p1, idx_p2;
  logic [23:0]       rgb_p3;
  logic              vld_p0, vld_p1, vld_p2, opq_p3;

  always_ff @(posedge pixel_clk_in) begin
    // S0 -> S1
    in_box_p0 <= box_hit;
    addr_p0   <= addr;
    // S1 -> S2
    in_box_p1 <= in_box_p0;
    idx_p1    <= img_word(addr_p0);
    // S2 -> S3
    in_box_p2 <= in_box_p1;
    idx_p2    <= idx_p1;
    // S3 -> S4
    rgb_p3    <= pal_word(idx_p2);
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      opq_p3     <= 1'b0;
      opaque_out <= 1'b0;
      red_out    <= 8'd0;
      green_out  <= 8'd0;
      blue_out   <= 8'd0;
    end else begin
      // S0 -> S1
      vld_p0     <= 1'b1;
      // S1 -> S2
      vld_p1     <= vld_p0;
      // S2 -> S3
      vld_p2     <= vld_p1;
      // S3 -> S4
      opq_p3     <= vld_p2 && in_box_p2 && (idx_p2 != KEY);
      // S4 -> outputs
      opaque_out <= opq_p3;
      red_out    <= opq_p3 ? rgb_p3[23:16] : 8'd0;
      green_out  <= opq_p3 ? rgb_p3[15:8]  : 8'd0;
      blue_out   <= opq_p3 ? rgb_p3[7:0]   : 8'd0;
    end
  end

endmodule

// File: tb/tb_animated_sprite.sv
// -----------------------------------------------------------------------------
// tb_animated_sprite
//
// The DUT is built with WIDTH=256, HEIGHT=16, NUM_FRAMES=3, PAL_DEPTH=512,
// SCALE_LOG2=1, HOLD_FRAMES=2 and KEY_IDX=0.
//
// Pixel expectations are pushed into exp_q when a pixel is driven. A monitor
// pops and compares them when that pixel leaves the 5-cycle pipeline.
// Sequencer outputs are checked directly after each pulse.
//
// The bench's model of the artwork:
//   index  = (source column + source row + 16*frame) mod 512
//   colour = {idx[7:0], ~idx[7:0], idx >= 256 ? FF : 3C}
// -----------------------------------------------------------------------------
module tb_animated_sprite;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] x, hcount;
  logic [9:0]  y, vcount;
  logic        frame_start, anim_en, oneshot, restart;
  logic [1:0]  frame_idx;
  logic        done, opaque;
  logic [7:0]  red, green, blue;

  always #5 clk = ~clk;

  animated_sprite #(
    .WIDTH(256), .HEIGHT(16), .NUM_FRAMES(3), .PAL_DEPTH(512),
    .SCALE_LOG2(1), .HOLD_FRAMES(2), .KEY_IDX(0)
  ) dut (
    .pixel_clk_in(clk), .rst_n_in(rst_n),
    .x_in(x), .y_in(y), .hcount_in(hcount), .vcount_in(vcount),
    .frame_start_in(frame_start), .anim_en_in(anim_en),
    .oneshot_in(oneshot), .restart_in(restart),
    .frame_idx_out(frame_idx), .done_out(done), .opaque_out(opaque),
    .red_out(red), .green_out(green), .blue_out(blue)
  );

  typedef struct {
    logic [24:0] v;
    int          hc;
    int          vc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [24:0] mon_got;
  logic [4:0]  pend;
  logic        drv_vld;
  int          n_tests = 0;
  int          n_fail  = 0;

  // Marks which cycles carried a driven pixel, delayed by the pipeline latency.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) pend <= '0;
    else        pend <= {pend[3:0], drv_vld};

  always @(negedge clk) begin
    if (pend[4]) begin
      mon_got = {opaque, red, green, blue};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pix_underflow: got %h, no expected entry queued", mon_got);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_got !== mon_e.v) begin
          n_fail++;
          $display("FAIL pix h=%0d v=%0d: got %h required %h", mon_e.hc, mon_e.vc, mon_got, mon_e.v);
        end
      end
    end
  end

  function automatic logic [24:0] exp_pix(input int hc, input int vc, input int xs,
                                          input int ys, input int fr);
    int dx, dy, idx;
    logic [7:0] lo;
    dx = hc - xs;
    dy = vc - ys;
    if (dx < 0 || dx >= 512 || dy < 0 || dy >= 32) return 25'd0;
    idx = (dx / 2 + dy / 2 + 16 * fr) % 512;
    if (idx == 0) return 25'd0;
    lo = 8'(idx);
    return {1'b1, lo, ~lo, (idx >= 256) ? 8'hFF : 8'h3C};
  endfunction

  task automatic chk(input string nm, input int got, input int req);
    n_tests++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, got, req);
    end
  endtask

  task automatic drive(input int hc, input int vc, input logic [24:0] e);
    @(negedge clk);
    hcount  = 11'(hc);
    vcount  = 10'(vc);
    drv_vld = 1'b1;
    exp_q.push_back('{e, hc, vc});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      drv_vld = 1'b0;
    end
  endtask

  task automatic pulse(input logic fs, input logic rs, input int ef, input int ed, input string nm);
    @(negedge clk);
    drv_vld     = 1'b0;
    frame_start = fs;
    restart     = rs;
    @(negedge clk);
    frame_start = 1'b0;
    restart     = 1'b0;
    chk({nm, "_frame"}, int'(frame_idx), ef);
    chk({nm, "_done"}, int'(done), ed);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ef_loop[8];
    int ef_one[7];
    int ed_one[7];
    ef_loop = '{0, 1, 1, 2, 2, 0, 0, 1};
    ef_one  = '{0, 1, 1, 2, 2, 2, 2};
    ed_one  = '{0, 0, 0, 0, 0, 1, 1};

    rst_n = 1'b0; x = 11'd100; y = 10'd50; hcount = 11'd102; vcount = 10'd50;
    frame_start = 1'b0; anim_en = 1'b0; oneshot = 1'b0; restart = 1'b0; drv_vld = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_opaque", int'(opaque), 0);
    chk("rst_rgb", int'({red, green, blue}), 0);
    chk("rst_frame", int'(frame_idx), 0);
    chk("rst_done", int'(done), 0);

    // release with an opaque pixel already presented: nothing for 4 cycles, then it appears
    @(negedge clk);
    rst_n   = 1'b1;
    drv_vld = 1'b1;
    exp_q.push_back('{{1'b1, 8'h01, 8'hFE, 8'h3C}, 102, 50});
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("release_lat%0d", i), int'(opaque), 0);
      exp_q.push_back('{{1'b1, 8'h01, 8'hFE, 8'h3C}, 102, 50});
    end
    idle(6);

    // colour key and box edges, hand-computed
    drive(100, 50, 25'd0);                          // col0 row0 -> index 0 = key
    drive(101, 50, 25'd0);                          // same source pixel (x2 scale)
    drive(102, 50, {1'b1, 8'h01, 8'hFE, 8'h3C});    // neighbour, index 1
    drive(103, 50, {1'b1, 8'h01, 8'hFE, 8'h3C});
    drive(100, 51, 25'd0);                          // still source row 0
    drive(100, 52, {1'b1, 8'h01, 8'hFE, 8'h3C});    // row 1 col 0 -> index 1
    drive(99,  52, 25'd0);                          // left of box
    drive(100, 49, 25'd0);                          // above box
    drive(100, 81, {1'b1, 8'h0F, 8'hF0, 8'h3C});    // last row (15)
    drive(100, 82, 25'd0);                          // below box
    drive(611, 52, {1'b1, 8'h00, 8'hFF, 8'hFF});    // last column, index 256
    drive(612, 52, 25'd0);                          // right of box
    idle(6);

    // horizontal sweep through the whole box with 2x upscale
    for (int hc = 99; hc <= 612; hc++) drive(hc, 52, exp_pix(hc, 52, 100, 50, 0));
    idle(6);

    // box hanging off the right edge must not wrap into low columns
    x = 11'd2000;
    for (int hc = 0; hc <= 7; hc++) drive(hc, 52, 25'd0);
    for (int hc = 2040; hc <= 2047; hc++) drive(hc, 52, exp_pix(hc, 52, 2000, 50, 0));
    drive(2047, 52, {1'b1, 8'h18, 8'hE7, 8'h3C});   // col 23 + row 1 -> index 24
    idle(6);
    x = 11'd100;

    // looping sequencer, 3 frames held 2 video frames each
    anim_en = 1'b1;
    for (int i = 0; i < 8; i++) pulse(1'b1, 1'b0, ef_loop[i], 0, $sformatf("loop%0d", i));

    // frame 1 artwork is 16 rows further down the index ROM
    drive(100, 50, {1'b1, 8'h10, 8'hEF, 8'h3C});
    drive(102, 50, {1'b1, 8'h11, 8'hEE, 8'h3C});
    idle(6);

    // pause freezes frame and hold count
    anim_en = 1'b0;
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, 1, 0, "pause");
    anim_en = 1'b1;
    pulse(1'b1, 1'b0, 1, 0, "resume_a");
    pulse(1'b1, 1'b0, 2, 0, "resume_b");

    // oneshot: stop on the last frame with done set
    pulse(1'b0, 1'b1, 0, 0, "restart");
    oneshot = 1'b1;
    for (int i = 0; i < 7; i++) pulse(1'b1, 1'b0, ef_one[i], ed_one[i], $sformatf("oneshot%0d", i));
    // restart beats a simultaneous frame_start (hold count must not advance)
    pulse(1'b1, 1'b1, 0, 0, "restart_fs");
    pulse(1'b1, 1'b0, 0, 0, "post_restart_a");
    pulse(1'b1, 1'b0, 1, 0, "post_restart_b");

    // reset with opaque frame-1 pixels in flight
    for (int i = 0; i < 8; i++) drive(102, 50, {1'b1, 8'h11, 8'hEE, 8'h3C});
    @(posedge clk);
    #2;
    rst_n   = 1'b0;
    drv_vld = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_opaque", int'(opaque), 0);
    chk("midrst_rgb", int'({red, green, blue}), 0);
    chk("midrst_frame", int'(frame_idx), 0);
    chk("midrst_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(102, 50, {1'b1, 8'h01, 8'hFE, 8'h3C});    // back on frame 0
    idle(7);

    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
